// File: rtl/mem_read_scheduler.sv
// rtl/mem_read_scheduler.sv - N-master AXI read burst scheduler (optional stats: MEM_SCHED_STATS_EN)
module mem_read_scheduler #(
    parameter int                   N_MASTERS     = 3,
    parameter int                   ADDR_WIDTH    = 26,
    parameter int                   DATA_WIDTH    = 32,
    parameter logic [N_MASTERS-1:0] PREFETCH_MASK = 3'b100,
    parameter int                   AGE_LIMIT     = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [N_MASTERS-1:0]            m_arvalid,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0] m_araddr,
    input  logic [N_MASTERS*4-1:0]          m_arlen,
    output logic [N_MASTERS-1:0]            m_arready,
    output logic [N_MASTERS-1:0]            m_rvalid,
    output logic                            m_rlast,
    output logic [DATA_WIDTH-1:0]           m_rdata,
    output logic                            ARVALID,
    input  logic                            ARREADY,
    output logic [3:0]                      ARID,
    output logic [3:0]                      ARLEN,
    output logic [ADDR_WIDTH-1:0]           ARADDR,
    input  logic                            RVALID,
    output logic                            RREADY,
    input  logic                            RLAST,
    input  logic [3:0]                      RID,
    input  logic [DATA_WIDTH-1:0]           RDATA,
    output logic [N_MASTERS*16-1:0]         stat_grants,
    output logic [15:0]                     stat_wait
);
    localparam int IW  = $clog2(N_MASTERS);
    localparam int AGW = $clog2(AGE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t                state;
    logic [IW-1:0]         rr_ptr;
    logic [IW-1:0]         lat_id;
    logic [AGW-1:0]        age [N_MASTERS];
    logic [IW-1:0]         win;
    logic [IW-1:0]         win_next;
    logic                  found;
    int                    best_d;
    int                    d;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [3:0]            sel_len;
    logic                  beat_ok;

    // Aged prefetch first, then demand round-robin from rr_ptr, then lowest prefetch.
    always_comb begin
        win      = '0;
        found    = 1'b0;
        best_d   = N_MASTERS;
        d        = 0;
        sel_addr = '0;
        sel_len  = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (!found && m_arvalid[i] && PREFETCH_MASK[i] && age[i] == AGW'(AGE_LIMIT)) begin
                win   = IW'(i);
                found = 1'b1;
            end
        end
        if (!found) begin
            for (int i = 0; i < N_MASTERS; i++) begin
                d = (i + N_MASTERS - int'(rr_ptr)) % N_MASTERS;
                if (m_arvalid[i] && !PREFETCH_MASK[i] && d < best_d) begin
                    best_d = d;
                    win    = IW'(i);
                end
            end
            if (best_d < N_MASTERS) found = 1'b1;
        end
        if (!found) begin
            for (int i = N_MASTERS - 1; i >= 0; i--) begin
                if (m_arvalid[i] && PREFETCH_MASK[i]) win = IW'(i);
            end
        end
        for (int i = 0; i < N_MASTERS; i++) begin
            if (win == IW'(i)) begin
                sel_addr = m_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_len  = m_arlen[i*4 +: 4];
            end
        end
        win_next = (int'(win) == N_MASTERS - 1) ? '0 : win + 1'b1;
    end

    assign ARID = 4'(lat_id);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            lat_id    <= '0;
            ARVALID   <= 1'b0;
            ARADDR    <= '0;
            ARLEN     <= '0;
            RREADY    <= 1'b0;
            m_arready <= '0;
            for (int i = 0; i < N_MASTERS; i++) age[i] <= '0;
        end else begin
            m_arready <= '0;
            case (state)
                IDLE: begin
                    if (|m_arvalid) begin
                        state   <= ADDR;
                        ARVALID <= 1'b1;
                        ARADDR  <= sel_addr;
                        ARLEN   <= sel_len;
                        lat_id  <= win;
                        if (!PREFETCH_MASK[win]) rr_ptr <= win_next;
                        for (int i = 0; i < N_MASTERS; i++) begin
                            m_arready[i] <= (win == IW'(i));
                            if (PREFETCH_MASK[i]) begin
                                if (win == IW'(i))
                                    age[i] <= '0;
                                else if (m_arvalid[i] && age[i] != AGW'(AGE_LIMIT))
                                    age[i] <= age[i] + 1'b1;
                            end
                        end
                    end
                end
                ADDR: begin
                    if (ARREADY) begin
                        ARVALID <= 1'b0;
                        RREADY  <= 1'b1;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (beat_ok && RLAST) begin
                        RREADY <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Beats with a foreign RID are still accepted (RREADY=1) but never reach a master.
    assign beat_ok = (state == DATA) && RVALID && (RID == 4'(lat_id));
    assign m_rdata = beat_ok ? RDATA : '0;
    assign m_rlast = beat_ok && RLAST;

    always_comb begin
        m_rvalid = '0;
        for (int i = 0; i < N_MASTERS; i++) m_rvalid[i] = beat_ok && (lat_id == IW'(i));
    end

`ifdef MEM_SCHED_STATS_EN
    logic [15:0] grant_cnt [N_MASTERS];
    logic [15:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            for (int i = 0; i < N_MASTERS; i++) grant_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_MASTERS; i++) begin
                if (m_arready[i] && grant_cnt[i] != 16'hFFFF) grant_cnt[i] <= grant_cnt[i] + 16'd1;
            end
            if (state != IDLE && |m_arvalid && wait_cnt != 16'hFFFF) wait_cnt <= wait_cnt + 16'd1;
        end
    end

    always_comb begin
        stat_grants = '0;
        for (int i = 0; i < N_MASTERS; i++) stat_grants[i*16 +: 16] = grant_cnt[i];
    end
    assign stat_wait = wait_cnt;
`else
    assign stat_grants = '0;
    assign stat_wait   = '0;
`endif

endmodule

// File: tb/tb_mem_read_scheduler.sv
// tb/tb_mem_read_scheduler.sv - directed self-checking bench for mem_read_scheduler
module tb_mem_read_scheduler;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  m_arvalid;
    logic [77:0] m_araddr;
    logic [11:0] m_arlen;
    logic [2:0]  m_arready;
    logic [2:0]  m_rvalid;
    logic        m_rlast;
    logic [31:0] m_rdata;
    logic        ARVALID;
    logic        ARREADY;
    logic [3:0]  ARID;
    logic [3:0]  ARLEN;
    logic [25:0] ARADDR;
    logic        RVALID;
    logic        RREADY;
    logic        RLAST;
    logic [3:0]  RID;
    logic [31:0] RDATA;
    logic [47:0] stat_grants;
    logic [15:0] stat_wait;

    int tests = 0;
    int fails = 0;
    logic saw2;

    mem_read_scheduler dut (
        .clk(clk), .rst_n(rst_n),
        .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_arready(m_arready), .m_rvalid(m_rvalid), .m_rlast(m_rlast), .m_rdata(m_rdata),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARID(ARID), .ARLEN(ARLEN), .ARADDR(ARADDR),
        .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST), .RID(RID), .RDATA(RDATA),
        .stat_grants(stat_grants), .stat_wait(stat_wait)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (m_arready[2]) saw2 = 1'b1;

    task automatic do_reset();
        rst_n = 1'b0; m_arvalid = '0; m_araddr = '0; m_arlen = '0;
        ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0; RID = '0; RDATA = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic serve_one(output int id);
        int n;
        n = 0;
        id = -1;
        while (!ARVALID && n < 20) begin @(negedge clk); n++; end
        tests++;
        if (!ARVALID) begin
            fails++; $display("FAIL serve_timeout ARVALID=%0b required 1", ARVALID);
            return;
        end
        id = int'(ARID);
        @(negedge clk);
        RVALID = 1'b1; RID = 4'(id); RLAST = 1'b1; RDATA = 32'h5A5A_0000 + 32'(id);
        @(negedge clk);
        RVALID = 1'b0; RLAST = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (ARVALID !== 1'b0) begin fails++; $display("FAIL reset_arvalid got %0b want 0", ARVALID); end
        tests++; if (RREADY !== 1'b0) begin fails++; $display("FAIL reset_rready got %0b want 0", RREADY); end
        tests++; if (m_arready !== 3'b000) begin fails++; $display("FAIL reset_m_arready got %b want 000", m_arready); end
        tests++; if (stat_wait !== 16'h0 || stat_grants !== 48'h0) begin
            fails++; $display("FAIL reset_stats got %h/%h want 0/0", stat_wait, stat_grants); end
    endtask

    task automatic test_single();
        do_reset();
        m_arvalid = 3'b001; m_araddr[25:0] = 26'h100; m_arlen[3:0] = 4'd3;
        @(negedge clk);
        tests++; if (ARVALID !== 1'b1 || ARID !== 4'd0 || ARADDR !== 26'h100 || ARLEN !== 4'd3) begin
            fails++; $display("FAIL single_ar got v=%0b id=%0d a=%h l=%0d want 1/0/100/3", ARVALID, ARID, ARADDR, ARLEN); end
        tests++; if (m_arready !== 3'b001) begin fails++; $display("FAIL single_arready got %b want 001", m_arready); end
        m_arvalid = '0; ARREADY = 1'b1;
        @(negedge clk);
        tests++; if (RREADY !== 1'b1 || ARVALID !== 1'b0) begin
            fails++; $display("FAIL single_data_entry got rr=%0b arv=%0b want 1/0", RREADY, ARVALID); end
        for (int b = 0; b < 4; b++) begin
            RVALID = 1'b1; RID = 4'd0; RDATA = 32'hA0 + 32'(b); RLAST = (b == 3);
            #1;
            tests++; if (m_rvalid !== 3'b001 || m_rdata !== 32'hA0 + 32'(b) || m_rlast !== (b == 3)) begin
                fails++; $display("FAIL single_beat%0d got v=%b d=%h l=%0b want 001/%h/%0b", b, m_rvalid, m_rdata, m_rlast, 32'hA0 + 32'(b), b == 3); end
            @(negedge clk);
        end
        RVALID = 1'b0; RLAST = 1'b0;
        tests++; if (RREADY !== 1'b0 || ARVALID !== 1'b0) begin
            fails++; $display("FAIL single_idle got rr=%0b arv=%0b want 0/0", RREADY, ARVALID); end
`ifdef MEM_SCHED_STATS_EN
        tests++; if (stat_grants[15:0] !== 16'd1) begin fails++; $display("FAIL single_stat_grant got %0d want 1", stat_grants[15:0]); end
`endif
    endtask

    task automatic test_contention();
        int id;
        int exp_ids [4] = '{0, 1, 0, 1};
        do_reset();
        saw2 = 1'b0;
        ARREADY = 1'b1; m_arvalid = 3'b011;
        m_araddr[25:0] = 26'h40; m_araddr[51:26] = 26'h80;
        for (int k = 0; k < 4; k++) begin
            serve_one(id);
            tests++; if (id !== exp_ids[k]) begin fails++; $display("FAIL contention_grant%0d got %0d want %0d", k, id, exp_ids[k]); end
        end
        tests++; if (saw2 !== 1'b0) begin fails++; $display("FAIL contention_no_m2 got %0b want 0", saw2); end
        m_arvalid = '0;
    endtask

    task automatic test_aging();
        int id;
        int exp_ids [18] = '{0, 1, 0, 1, 0, 1, 0, 1, 2, 0, 1, 0, 1, 0, 1, 0, 1, 2};
        do_reset();
        ARREADY = 1'b1; m_arvalid = 3'b111;
        for (int k = 0; k < 18; k++) begin
            serve_one(id);
            tests++; if (id !== exp_ids[k]) begin fails++; $display("FAIL aging_grant%0d got %0d want %0d", k, id, exp_ids[k]); end
        end
        m_arvalid = '0;
    endtask

    task automatic test_backpressure_stray();
        do_reset();
        m_arvalid = 3'b010; m_araddr[51:26] = 26'h2A0; m_arlen[7:4] = 4'd1;
        @(negedge clk);
        m_arvalid = '0; m_araddr = '0;
        for (int c = 0; c < 5; c++) begin
            tests++; if (ARVALID !== 1'b1 || ARADDR !== 26'h2A0 || ARID !== 4'd1 || ARLEN !== 4'd1 || RREADY !== 1'b0) begin
                fails++; $display("FAIL bp_hold%0d got v=%0b a=%h id=%0d l=%0d rr=%0b want 1/2a0/1/1/0", c, ARVALID, ARADDR, ARID, ARLEN, RREADY); end
            @(negedge clk);
        end
        ARREADY = 1'b1;
        @(negedge clk);
        ARREADY = 1'b0;
        tests++; if (RREADY !== 1'b1 || ARVALID !== 1'b0) begin
            fails++; $display("FAIL bp_data got rr=%0b arv=%0b want 1/0", RREADY, ARVALID); end
        RVALID = 1'b1; RID = 4'd2; RLAST = 1'b1; RDATA = 32'hDEAD;
        #1;
        tests++; if (m_rvalid !== 3'b000 || m_rlast !== 1'b0) begin
            fails++; $display("FAIL stray_beat got v=%b l=%0b want 000/0", m_rvalid, m_rlast); end
        @(negedge clk);
        tests++; if (RREADY !== 1'b1) begin fails++; $display("FAIL stray_stay got rr=%0b want 1", RREADY); end
        RID = 4'd1; RLAST = 1'b0; RDATA = 32'h11;
        #1;
        tests++; if (m_rvalid !== 3'b010 || m_rdata !== 32'h11) begin
            fails++; $display("FAIL stray_next got v=%b d=%h want 010/11", m_rvalid, m_rdata); end
        @(negedge clk);
        RLAST = 1'b1; RDATA = 32'h22;
        #1;
        tests++; if (m_rvalid !== 3'b010 || m_rlast !== 1'b1) begin
            fails++; $display("FAIL stray_last got v=%b l=%0b want 010/1", m_rvalid, m_rlast); end
        @(negedge clk);
        RVALID = 1'b0; RLAST = 1'b0;
        tests++; if (RREADY !== 1'b0) begin fails++; $display("FAIL stray_done got rr=%0b want 0", RREADY); end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        ARREADY = 1'b1; m_arvalid = 3'b001; m_araddr[25:0] = 26'h300; m_arlen[3:0] = 4'd3;
        @(negedge clk);
        m_arvalid = '0;
        @(negedge clk);
        for (int b = 0; b < 2; b++) begin
            RVALID = 1'b1; RID = 4'd0; RLAST = 1'b0; RDATA = 32'(b);
            @(negedge clk);
        end
        RVALID = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tests++; if (ARVALID !== 1'b0 || RREADY !== 1'b0 || m_arready !== 3'b000) begin
            fails++; $display("FAIL rst_mid got arv=%0b rr=%0b ard=%b want 0/0/000", ARVALID, RREADY, m_arready); end
        tests++; if (stat_wait !== 16'h0 || stat_grants !== 48'h0) begin
            fails++; $display("FAIL rst_mid_stats got %h/%h want 0/0", stat_wait, stat_grants); end
        RVALID = 1'b1; RID = 4'd0; RLAST = 1'b1;
        #1;
        tests++; if (m_rvalid !== 3'b000) begin fails++; $display("FAIL rst_mid_beat got %b want 000", m_rvalid); end
        @(negedge clk);
        RVALID = 1'b0; RLAST = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_aging();
        test_backpressure_stray();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
